// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared widths and FSM state type for the line/burst adaptor
package cacheline_adaptor_pkg;
    localparam int LINE_WIDTH  = 256;
    localparam int BURST_WIDTH = 64;
    localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: gathers four 64-bit memory beats into a 256-bit cache line and
// splits a 256-bit writeback line into four beats.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            address_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    output logic [31:0]            address_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i
);
    adaptor_state_t        state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] buf_q, buf_d;
    logic [31:0]           addr_q, addr_d;
    logic                  last;

    assign last      = cnt_q == 2'(BEATS - 1);
    assign read_o    = state_q == READ;
    assign write_o   = state_q == WRITE;
    assign resp_o    = state_q == DONE;
    assign address_o = addr_q;
    assign line_o    = buf_q;
    assign burst_o   = write_o ? buf_q[BURST_WIDTH*int'(cnt_q) +: BURST_WIDTH] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

    // The 2-bit count wraps 3->0 naturally on the final beat, leaving it cleared for DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (read_i || write_i) begin
                    addr_d  = {address_i[31:5], 5'b0};
                    cnt_d   = '0;
                    state_d = read_i ? READ : WRITE;
                    if (!read_i) buf_d = line_i;
                end
            end
            READ: begin
                if (resp_i) begin
                    buf_d[BURST_WIDTH*int'(cnt_q) +: BURST_WIDTH] = burst_i;
                    cnt_d   = cnt_q + 2'd1;
                    state_d = last ? DONE : READ;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = last ? DONE : WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed checks of read gather, write split, stalls, reset abort
// and request arbitration.
module tb_cacheline_adaptor;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         read_i, write_i, resp_o;
    logic [31:0]  address_o;
    logic [63:0]  burst_i, burst_o;
    logic         read_o, write_o, resp_i;
    int           tests = 0;
    int           fails = 0;
    int           pulses = 0;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst), .address_i(address_i), .line_i(line_i), .line_o(line_o),
        .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .address_o(address_o),
        .burst_i(burst_i), .burst_o(burst_o), .read_o(read_o), .write_o(write_o),
        .resp_i(resp_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (resp_o === 1'b1) pulses++;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [255:0] wline;
        logic [63:0]  wbeat [4];
        int           p0;
        rst = 1'b1; address_i = '0; line_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        check("rst_resp", 256'(resp_o), 256'd0);
        check("rst_read", 256'(read_o), 256'd0);
        check("rst_write", 256'(write_o), 256'd0);
        check("rst_addr", 256'(address_o), 256'd0);
        check("rst_burst", 256'(burst_o), 256'd0);
        check("rst_line", line_o, 256'd0);

        // 1: contiguous read
        read_i = 1'b1; address_i = 32'h0000_1234;
        tick;
        check("t1_read_o", 256'(read_o), 256'd1);
        check("t1_addr", 256'(address_o), 256'h0000_1220);
        resp_i = 1'b1;
        burst_i = 64'h1111_1111_1111_1111; tick; check("t1_resp_c2", 256'(resp_o), 256'd0);
        burst_i = 64'h2222_2222_2222_2222; tick; check("t1_resp_c3", 256'(resp_o), 256'd0);
        burst_i = 64'h3333_3333_3333_3333; tick; check("t1_resp_c4", 256'(resp_o), 256'd0);
        burst_i = 64'h4444_4444_4444_4444; tick;
        check("t1_resp_c5", 256'(resp_o), 256'd1);
        check("t1_read_done", 256'(read_o), 256'd0);
        check("t1_line", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        read_i = 1'b0; resp_i = 1'b0;
        tick;
        check("t1_resp_drop", 256'(resp_o), 256'd0);
        check("t1_idle_read", 256'(read_o), 256'd0);
        check("t1_line_hold", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // 2: write split, line_i changed after acceptance must not matter
        wline = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
        wbeat[0] = 64'h8796a5b4c3d2e1f0; wbeat[1] = 64'h0f1e2d3c4b5a6978;
        wbeat[2] = 64'hfedcba9876543210; wbeat[3] = 64'h0123456789abcdef;
        write_i = 1'b1; address_i = 32'h8000_0040; line_i = wline;
        tick;
        line_i = ~wline; resp_i = 1'b1;
        check("t2_write_o", 256'(write_o), 256'd1);
        check("t2_read_o", 256'(read_o), 256'd0);
        check("t2_addr", 256'(address_o), 256'h8000_0040);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_beat%0d", k), 256'(burst_o), 256'(wbeat[k]));
            check($sformatf("t2_resp_b%0d", k), 256'(resp_o), 256'd0);
            tick;
        end
        check("t2_resp", 256'(resp_o), 256'd1);
        check("t2_write_drop", 256'(write_o), 256'd0);
        write_i = 1'b0; resp_i = 1'b0;
        tick;

        // 3: stalled read with resp_i pattern 1,0,0,1,1,0,1
        read_i = 1'b1; address_i = 32'h0000_201f;
        tick;
        check("t3_addr", 256'(address_o), 256'h0000_2000);
        resp_i = 1'b1; burst_i = 64'haaaa_0000_0000_0001; tick;
        check("t3_beat_a", 256'(line_o[63:0]), 256'h aaaa_0000_0000_0001);
        resp_i = 1'b0; burst_i = 64'hdead_dead_dead_dead; tick;
        resp_i = 1'b0; burst_i = 64'hbeef_beef_beef_beef; tick;
        check("t3_stall_hold", 256'(line_o[127:0]),
              {64'hfedcba9876543210 ^ 64'h0, 64'haaaa_0000_0000_0001} & {64'h0, 64'hffff_ffff_ffff_ffff}
              | {line_o[127:64], 64'h0});
        resp_i = 1'b1; burst_i = 64'hbbbb_0000_0000_0002; tick;
        resp_i = 1'b1; burst_i = 64'hcccc_0000_0000_0003; tick;
        resp_i = 1'b0; burst_i = 64'hdead_dead_dead_dead; tick;
        check("t3_read_stalled", 256'(read_o), 256'd1);
        resp_i = 1'b1; burst_i = 64'hdddd_0000_0000_0004; tick;
        check("t3_resp_c8", 256'(resp_o), 256'd1);
        check("t3_line", line_o, {64'hdddd_0000_0000_0004, 64'hcccc_0000_0000_0003,
                                  64'hbbbb_0000_0000_0002, 64'haaaa_0000_0000_0001});
        read_i = 1'b0; resp_i = 1'b0;
        tick;

        // 4: reset after two read beats, then a fresh read
        read_i = 1'b1; address_i = 32'h0000_0040;
        tick;
        resp_i = 1'b1;
        burst_i = 64'hbad1_bad1_bad1_bad1; tick;
        burst_i = 64'hbad2_bad2_bad2_bad2; tick;
        rst = 1'b1; read_i = 1'b0; resp_i = 1'b0;
        tick;
        rst = 1'b0;
        check("t4_read_o", 256'(read_o), 256'd0);
        check("t4_line_clr", line_o, 256'd0);
        check("t4_addr_clr", 256'(address_o), 256'd0);
        read_i = 1'b1; address_i = 32'h0000_0080;
        tick;
        resp_i = 1'b1;
        burst_i = 64'h5555_0000_0000_0005; tick;
        burst_i = 64'h6666_0000_0000_0006; tick;
        burst_i = 64'h7777_0000_0000_0007; tick;
        burst_i = 64'h8888_0000_0000_0008; tick;
        check("t4_resp", 256'(resp_o), 256'd1);
        check("t4_line", line_o, {64'h8888_0000_0000_0008, 64'h7777_0000_0000_0007,
                                  64'h6666_0000_0000_0006, 64'h5555_0000_0000_0005});
        read_i = 1'b0; resp_i = 1'b0;
        tick;

        // 5: read and write requested together; read wins
        read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_0100; line_i = {4{64'hffff_ffff_ffff_ffff}};
        tick;
        check("t5_read_o", 256'(read_o), 256'd1);
        check("t5_write_o", 256'(write_o), 256'd0);
        resp_i = 1'b1;
        burst_i = 64'h0000_0000_0000_00a1; tick;
        burst_i = 64'h0000_0000_0000_00a2; tick;
        burst_i = 64'h0000_0000_0000_00a3; tick;
        burst_i = 64'h0000_0000_0000_00a4; tick;
        check("t5_resp", 256'(resp_o), 256'd1);
        check("t5_line", line_o, {64'h00a4, 64'h00a3, 64'h00a2, 64'h00a1});
        read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        tick;

        // 6: write then read, each held until its resp_o; junk beats around DONE/IDLE
        p0 = pulses;
        write_i = 1'b1; address_i = 32'h0000_0200; line_i = wline;
        tick;
        resp_i = 1'b1; burst_i = 64'h9999_9999_9999_9999;
        tick; tick; tick; tick;
        check("t6_wresp", 256'(resp_o), 256'd1);
        write_i = 1'b0; read_i = 1'b1; address_i = 32'h0000_0300;
        tick;
        check("t6_idle_gap", 256'(read_o | write_o), 256'd0);
        tick;
        check("t6_read_start", 256'(read_o), 256'd1);
        check("t6_raddr", 256'(address_o), 256'h0000_0300);
        burst_i = 64'h0000_0000_0000_0b01; tick;
        burst_i = 64'h0000_0000_0000_0b02; tick;
        burst_i = 64'h0000_0000_0000_0b03; tick;
        burst_i = 64'h0000_0000_0000_0b04; tick;
        check("t6_rresp", 256'(resp_o), 256'd1);
        check("t6_line", line_o, {64'h0b04, 64'h0b03, 64'h0b02, 64'h0b01});
        read_i = 1'b0; resp_i = 1'b0;
        tick;
        tick;
        check("t6_pulses", 256'(pulses - p0), 256'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
